// File: rtl/lcd_frame_packetizer_if.sv
// Pixel-stream and FIFO-write signal bundle for the LCD frame packetizer.
// master = pixel source / FIFO side, slave = packetizer.
interface lcd_frame_packetizer_if;
    logic        pix_valid;
    logic        pix_sof;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        queue_full;
    logic        queue_wr_en;
    logic [16:0] queue_data;

    modport master (
        output pix_valid, pix_sof, pix_data, queue_full,
        input  pix_ready, queue_wr_en, queue_data
    );

    modport slave (
        input  pix_valid, pix_sof, pix_data, queue_full,
        output pix_ready, queue_wr_en, queue_data
    );
endinterface

// File: rtl/lcd_frame_packetizer.sv
// Frames an RGB565 pixel stream into marker-delimited 17-bit words for the LCD pixel queue,
// resynchronising on a mid-frame start-of-frame and dropping pixels outside a frame.
module lcd_frame_packetizer #(
    parameter int          WIDTH            = 480,
    parameter int          HEIGHT           = 272,
    parameter logic [16:0] MARK_FRAME_START = 17'h10000,
    parameter logic [16:0] MARK_ROW_START   = 17'h10001,
    parameter logic [16:0] MARK_FRAME_END   = 17'h1FFFF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    lcd_frame_packetizer_if.slave  bus,
    output logic [15:0]            frame_count,
    output logic                   resync_err
);

    typedef enum logic [2:0] {
        WAIT_SOF    = 3'd0,
        EMIT_FSTART = 3'd1,
        EMIT_RSTART = 3'd2,
        PIXELS      = 3'd3,
        EMIT_FEND   = 3'd4
    } state_t;

    localparam logic [10:0] COL_LAST = 11'(WIDTH - 1);
    localparam logic [10:0] ROW_LAST = 11'(HEIGHT - 1);

    state_t      state_r;
    logic        out_valid_r;
    logic [16:0] out_data_r;
    logic [10:0] col_r;
    logic [10:0] row_r;
    logic [15:0] frame_count_r;
    logic        resync_err_r;
    logic        abort_r;
    logic        ready_en_r;

    logic        slot_free_s;
    logic        wr_s;
    logic        first_s;
    logic        ready_s;
    logic        accept_s;
    logic        sof_hit_s;

    // Slot availability, pixel handshake and mid-frame SOF detection.
    always_comb begin
        slot_free_s = !out_valid_r || !bus.queue_full;
        wr_s        = out_valid_r && !bus.queue_full;
        first_s     = (row_r == 11'd0) && (col_r == 11'd0);
        ready_s     = 1'b0;
        case (state_r)
            WAIT_SOF: ready_s = slot_free_s && !bus.pix_sof;
            PIXELS:   ready_s = slot_free_s && !(bus.pix_sof && !first_s);
            default:  ready_s = 1'b0;
        endcase
        // ready_en_r keeps pix_ready low while in and just out of reset
        if (!ready_en_r) begin
            ready_s = 1'b0;
        end else begin
            ready_s = ready_s;
        end
        accept_s  = bus.pix_valid && ready_s;
        sof_hit_s = (state_r == PIXELS) && bus.pix_valid && bus.pix_sof
                    && !first_s && slot_free_s;
    end

    assign bus.pix_ready   = ready_s;
    assign bus.queue_wr_en = wr_s;
    assign bus.queue_data  = out_data_r;
    assign frame_count     = frame_count_r;
    assign resync_err      = resync_err_r;

    // Framing FSM with the one-entry output slot; a load in the same cycle as a write wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= WAIT_SOF;
            out_valid_r   <= 1'b0;
            out_data_r    <= 17'd0;
            col_r         <= 11'd0;
            row_r         <= 11'd0;
            frame_count_r <= 16'd0;
            resync_err_r  <= 1'b0;
            abort_r       <= 1'b0;
            ready_en_r    <= 1'b0;
        end else begin
            ready_en_r   <= 1'b1;
            resync_err_r <= 1'b0;
            if (wr_s) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                WAIT_SOF: begin
                    if (bus.pix_valid && bus.pix_sof) begin
                        state_r <= EMIT_FSTART;
                    end
                end
                EMIT_FSTART: begin
                    if (slot_free_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= MARK_FRAME_START;
                        row_r       <= 11'd0;
                        state_r     <= EMIT_RSTART;
                    end
                end
                EMIT_RSTART: begin
                    if (slot_free_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= MARK_ROW_START;
                        col_r       <= 11'd0;
                        state_r     <= PIXELS;
                    end
                end
                PIXELS: begin
                    if (accept_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= {1'b0, bus.pix_data};
                        col_r       <= col_r + 11'd1;
                        if (col_r == COL_LAST) begin
                            if (row_r == ROW_LAST) begin
                                state_r <= EMIT_FEND;
                            end else begin
                                row_r   <= row_r + 11'd1;
                                state_r <= EMIT_RSTART;
                            end
                        end
                    end else if (sof_hit_s) begin
                        // leave the SOF pixel pending; it opens the next frame
                        resync_err_r <= 1'b1;
                        abort_r      <= 1'b1;
                        state_r      <= EMIT_FEND;
                    end
                end
                EMIT_FEND: begin
                    if (slot_free_s) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= MARK_FRAME_END;
                        if (abort_r) begin
                            abort_r <= 1'b0;
                            state_r <= EMIT_FSTART;
                        end else begin
                            frame_count_r <= frame_count_r + 16'd1;
                            state_r       <= WAIT_SOF;
                        end
                    end
                end
                default: begin
                    state_r <= WAIT_SOF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_packetizer.sv
// Directed bench for lcd_frame_packetizer (WIDTH=4, HEIGHT=2) with a write-stream scoreboard.
module tb_lcd_frame_packetizer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] frame_count;
    logic        resync_err;
    logic        full_bit = 1'b0;
    int          full_mode = 0;   // 0 released, 1 forced full, 2 random

    int checks = 0;
    int errors = 0;
    int mon_checks = 0;
    int mon_errors = 0;
    int rs_cnt = 0;
    int rd_base = 0;

    logic [16:0] got_q[$];
    logic [16:0] exp_q[$];

    lcd_frame_packetizer_if bus();

    lcd_frame_packetizer #(.WIDTH(4), .HEIGHT(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .frame_count (frame_count),
        .resync_err  (resync_err)
    );

    assign bus.queue_full = full_bit;

    always #5 clk = ~clk;

    // FIFO-full stimulus, changed only on the falling edge.
    always @(negedge clk) begin
        if (full_mode == 2) full_bit <= 1'($urandom_range(0, 1));
        else                full_bit <= (full_mode == 1);
    end

    // Capture every FIFO write, flag writes into a full FIFO, count resync pulses.
    always @(posedge clk) begin
        if (bus.queue_wr_en === 1'b1) begin
            got_q.push_back(bus.queue_data);
            mon_checks <= mon_checks + 1;
            assert (bus.queue_full === 1'b0) else begin
                mon_errors <= mon_errors + 1;
                $error("FAIL wr_while_full: queue_full=%b required 0", bus.queue_full);
            end
        end
        if (resync_err === 1'b1) rs_cnt <= rs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_pix(input logic [15:0] d, input logic sof);
        int   gap;
        logic done;
        gap  = (full_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        done = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
        end
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_sof   = sof;
        bus.pix_data  = d;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            if (bus.pix_ready === 1'b1) done = 1'b1;
        end
        chk("accept", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic push_frame(input logic [15:0] base);
        exp_q.push_back(17'h10000);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(17'h10001);
            for (int c = 0; c < 4; c++) exp_q.push_back({1'b0, base + 16'(r * 4 + c)});
        end
        exp_q.push_back(17'h1FFFF);
    endtask

    task automatic send_frame(input logic [15:0] base);
        for (int i = 0; i < 8; i++) send_pix(base + 16'(i), (i == 0));
        push_frame(base);
    endtask

    task automatic check_stream(input string tag);
        int n;
        n = got_q.size() - rd_base;
        chk({tag, "_len"}, 32'(n), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++) chk(tag, 32'(got_q[rd_base + i]), 32'(exp_q[i]));
        rd_base = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = 16'h0000;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.queue_wr_en), 32'd0);
        chk("rst_qdata", 32'(bus.queue_data), 32'd0);
        chk("rst_fcount", 32'(frame_count), 32'd0);
        chk("rst_resync", 32'(resync_err), 32'd0);
        chk("rst_ready", 32'(bus.pix_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: clean frame
        send_frame(16'h0001);
        idle(12);
        check_stream("s1_stream");
        chk("s1_fcount", 32'(frame_count), 32'd1);
        chk("s1_resync", 32'(rs_cnt), 32'd0);

        // 2: stray pixels before SOF are consumed and dropped
        send_pix(16'hAAA1, 1'b0);
        send_pix(16'hAAA2, 1'b0);
        send_pix(16'hAAA3, 1'b0);
        idle(5);
        chk("s2_drop", 32'(got_q.size() - rd_base), 32'd0);
        send_frame(16'h0011);
        idle(12);
        check_stream("s2_stream");
        chk("s2_fcount", 32'(frame_count), 32'd2);

        // 3: SOF after 5 pixels aborts the frame and starts a new one
        for (int i = 0; i < 5; i++) send_pix(16'h0021 + 16'(i), (i == 0));
        exp_q.push_back(17'h10000);
        exp_q.push_back(17'h10001);
        for (int i = 0; i < 4; i++) exp_q.push_back(17'h00021 + 17'(i));
        exp_q.push_back(17'h10001);
        exp_q.push_back(17'h00025);
        exp_q.push_back(17'h1FFFF);
        send_frame(16'h0030);
        idle(12);
        check_stream("s3_stream");
        chk("s3_resync", 32'(rs_cnt), 32'd1);
        chk("s3_fcount", 32'(frame_count), 32'd3);

        // 4: random back-pressure and gaps over three frames
        full_mode = 2;
        for (int f = 0; f < 3; f++) send_frame(16'h0100 + 16'(f * 16));
        idle(2);
        full_mode = 0;
        idle(20);
        check_stream("s4_stream");
        chk("s4_fcount", 32'(frame_count), 32'd6);

        // 5: FIFO full held 20 cycles mid-row
        send_pix(16'h0201, 1'b1);
        send_pix(16'h0202, 1'b0);
        idle(4);
        full_mode = 1;
        send_pix(16'h0203, 1'b0);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = 16'h0204;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            chk("s5_ready", 32'(bus.pix_ready), 32'd0);
            chk("s5_wr_en", 32'(bus.queue_wr_en), 32'd0);
            chk("s5_qdata", 32'(bus.queue_data), 32'h00203);
        end
        full_mode = 0;
        for (int i = 3; i < 8; i++) send_pix(16'h0201 + 16'(i), 1'b0);
        push_frame(16'h0201);
        idle(12);
        check_stream("s5_stream");
        chk("s5_fcount", 32'(frame_count), 32'd7);

        // 6: reset mid-row 1 abandons the frame
        for (int i = 0; i < 5; i++) send_pix(16'h0301 + 16'(i), (i == 0));
        @(negedge clk);
        bus.pix_valid = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("s6_wr_en", 32'(bus.queue_wr_en), 32'd0);
        chk("s6_qdata", 32'(bus.queue_data), 32'd0);
        chk("s6_fcount", 32'(frame_count), 32'd0);
        chk("s6_resync", 32'(resync_err), 32'd0);
        chk("s6_ready", 32'(bus.pix_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd_base = got_q.size();
        idle(3);
        chk("s6_fcount0", 32'(frame_count), 32'd0);
        send_frame(16'h0401);
        idle(12);
        check_stream("s6_stream");
        chk("s6_fcount1", 32'(frame_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks + mon_checks, errors + mon_errors);
        $finish;
    end

endmodule
